int_exec_arbiter: RTL
=====================

INT_EXEC_ARBITER -- requirements
Module: INT_EXEC_ARBITER

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 Parameter TAG_WIDTH, default 5, destination-register tag width.
REQ-003 clock_in  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 req0_valid_in, req1_valid_in  input  1 each  requester n presents an operation.
REQ-006 req0_ready_out, req1_ready_out  output  1 each  requester n's operation is accepted this cycle.
REQ-007 req0_a_in, req0_b_in, req1_a_in, req1_b_in  input  DATA_WIDTH each  operands.
REQ-008 req0_uop_in, req1_uop_in  input  4 each  integer micro-opcode.
REQ-009 req0_tag_in, req1_tag_in  input  TAG_WIDTH each  destination tag.
REQ-010 exec_a_out, exec_b_out  output  DATA_WIDTH  operands driven to the shared integer execution unit.
REQ-011 exec_uop_out  output  4  micro-opcode; exec_enable_out  output  1  high when a grant occurs.
REQ-012 exec_res_in  input  DATA_WIDTH  combinational result from the execution unit.
REQ-013 res_valid_out  output  1;  res_ready_in  input  1;  res_data_out  output  DATA_WIDTH;  res_tag_out  output  TAG_WIDTH;  res_src_out  output  1 (0 = req0, 1 = req1).

Function
REQ-014 The block shall hold a one-entry result register with states EMPTY and FULL.
REQ-015 can_accept = (state == EMPTY) or res_ready_in.
REQ-016 A grant occurs when can_accept is high and at least one valid is high; at most one requester shall be granted per cycle.
REQ-017 reqN_ready_out shall be high only for the granted requester, and only in the grant cycle.
REQ-018 The exec_* outputs shall be the granted requester's fields, combinationally; exec_enable_out shall equal the grant; exec_* outputs shall be all zero when no grant occurs.
REQ-019 On a grant, exec_res_in, the tag and the source shall be registered; state shall become FULL and res_valid_out shall be high the next cycle (latency 1).
REQ-020 FULL with res_ready_in high and no grant shall change state to EMPTY; FULL with res_ready_in high and a grant shall stay FULL and load the new result (back-to-back, one op per cycle).
REQ-021 FULL with res_ready_in low shall hold all result outputs stable and both ready outputs low.
REQ-022 With a single valid requester, it shall win regardless of the arbitration policy.
REQ-023 A requester's valid and fields shall not be required to stay stable across cycles; the block shall sample only in the grant cycle.

Reset
REQ-024 With reset_in high at a clock edge, state shall become EMPTY, res_valid_out 0, res_data_out 0, res_tag_out 0, res_src_out 0, and last_grant 1.
REQ-025 While reset_in is high, both ready outputs and exec_enable_out shall be 0.
REQ-026 A result pending at reset shall be discarded.

Configuration
REQ-027 Macro INT_EXEC_ARB_ROUND_ROBIN_EN defined: on simultaneous valids, the requester other than last_grant shall win; last_grant shall update on every grant.
REQ-028 Macro INT_EXEC_ARB_ROUND_ROBIN_EN undefined: req0 shall always win on simultaneous valids (fixed priority); last_grant shall not exist.

Structure
REQ-029 The uop encodings (ADD 0000, SUB 0001, OR 0010, AND 0011, XOR 0100, buffer rs1 1000, buffer rs2 1001, SLT 1010, SLTU 1011, SRA 1101, SRL 1110, SLL 1111) and state encodings shall live in a shared core package.
REQ-030 The grant logic shall be one sub-module, INT_EXEC_ARB_GRANT: inputs are both valids, can_accept and last_grant; outputs are a one-hot grant.
REQ-031 The execution unit shall be instantiated outside this block.

Verification
REQ-032 After reset, req0 only with a=5, b=3, uop=0001, tag=7, and the bench ALU model: next cycle res_valid_out=1, res_data_out=2, res_tag_out=7, res_src_out=0.
REQ-033 Both valids held for 4 cycles, res_ready_in=1, macro defined: grants are req0, req1, req0, req1; macro undefined: req0 on all 4 cycles.
REQ-034 res_ready_in=0 with FULL for 3 cycles and both valids high: ready outputs stay 0 and result outputs are unchanged; raising res_ready_in gives a grant in the same cycle.
REQ-035 Back-to-back req1 ops ADD 1+1 then XOR 6^3 with res_ready_in=1: results 2 then 5 on consecutive cycles, with no bubble.
REQ-036 reset_in asserted while FULL: next cycle res_valid_out=0; the first grant after reset goes to req0 when both are valid.

Source files
------------

// File: rtl/int_exec_arbiter_pkg.sv
// Shared core definitions for the integer execution arbiter:
// micro-opcode encodings, result-slot state encodings and requester helpers.
package int_exec_arbiter_pkg;

    // Number of requesters sharing the integer execution unit.
    localparam int NUM_REQ = 2;

    // Integer micro-opcodes understood by the shared execution unit.
    typedef enum logic [3:0] {
        UOP_ADD  = 4'b0000,
        UOP_SUB  = 4'b0001,
        UOP_OR   = 4'b0010,
        UOP_AND  = 4'b0011,
        UOP_XOR  = 4'b0100,
        UOP_RS1  = 4'b1000,
        UOP_RS2  = 4'b1001,
        UOP_SLT  = 4'b1010,
        UOP_SLTU = 4'b1011,
        UOP_SRA  = 4'b1101,
        UOP_SRL  = 4'b1110,
        UOP_SLL  = 4'b1111
    } uop_e;

    // One-entry result slot occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } res_state_e;

    // Source index of a one-hot grant (0 = req0, 1 = req1).
    function automatic logic grant_src(input logic [NUM_REQ-1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/int_exec_arb_grant.sv
// Grant selection for two requesters: one-hot, at most one per cycle.
// Optional feature macro: INT_EXEC_ARB_ROUND_ROBIN_EN (alternate on contention);
// without it req0 has fixed priority and last_grant is ignored.
module int_exec_arb_grant
    import int_exec_arbiter_pkg::*;
(
    input  logic               req0_valid,
    input  logic               req1_valid,
    input  logic               can_accept,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

`ifndef INT_EXEC_ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for the previous winner.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick a winner; a lone requester always wins, contention follows policy.
    always_comb begin
        grant = '0;
        if (can_accept) begin
            unique case ({req1_valid, req0_valid})
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11: begin
`ifdef INT_EXEC_ARB_ROUND_ROBIN_EN
                    grant = last_grant ? 2'b01 : 2'b10;
`else
                    grant = 2'b01;
`endif
                end
                default: grant = '0;
            endcase
        end
    end

endmodule

// File: rtl/int_exec_arbiter.sv
// Two-requester arbiter in front of a shared, external integer execution unit.
// Captures the unit's combinational result in a one-entry result slot
// (latency 1, one op per cycle when the consumer keeps res_ready_in high).
// Optional feature macro: INT_EXEC_ARB_ROUND_ROBIN_EN (round-robin on contention;
// default build is fixed priority to req0).
module int_exec_arbiter
    import int_exec_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  req0_valid_in,
    output logic                  req0_ready_out,
    input  logic [DATA_WIDTH-1:0] req0_a_in,
    input  logic [DATA_WIDTH-1:0] req0_b_in,
    input  logic [3:0]            req0_uop_in,
    input  logic [TAG_WIDTH-1:0]  req0_tag_in,
    input  logic                  req1_valid_in,
    output logic                  req1_ready_out,
    input  logic [DATA_WIDTH-1:0] req1_a_in,
    input  logic [DATA_WIDTH-1:0] req1_b_in,
    input  logic [3:0]            req1_uop_in,
    input  logic [TAG_WIDTH-1:0]  req1_tag_in,
    output logic [DATA_WIDTH-1:0] exec_a_out,
    output logic [DATA_WIDTH-1:0] exec_b_out,
    output logic [3:0]            exec_uop_out,
    output logic                  exec_enable_out,
    input  logic [DATA_WIDTH-1:0] exec_res_in,
    output logic                  res_valid_out,
    input  logic                  res_ready_in,
    output logic [DATA_WIDTH-1:0] res_data_out,
    output logic [TAG_WIDTH-1:0]  res_tag_out,
    output logic                  res_src_out
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [3:0]            uop;
        logic [TAG_WIDTH-1:0]  tag;
    } req_t;

    req_t               req0, req1, sel;
    res_state_e         state_q, state_d;
    logic               can_accept;
    logic [NUM_REQ-1:0] grant;
    logic               granted;
    logic               gnt_src;
    logic               lg_to_grant;

    assign req0 = '{a: req0_a_in, b: req0_b_in, uop: req0_uop_in, tag: req0_tag_in};
    assign req1 = '{a: req1_a_in, b: req1_b_in, uop: req1_uop_in, tag: req1_tag_in};

    // Slot can take a new result if empty or if it drains this cycle;
    // reset suppresses every grant.
    assign can_accept = !reset_in && ((state_q == ST_EMPTY) || res_ready_in);

`ifdef INT_EXEC_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    // Remember the most recent winner; reset favours req0 for the next contention.
    always_ff @(posedge clock_in) begin
        if (reset_in)
            last_grant_q <= 1'b1;
        else if (granted)
            last_grant_q <= gnt_src;
    end

    assign lg_to_grant = last_grant_q;
`else
    assign lg_to_grant = 1'b0;
`endif

    int_exec_arb_grant u_grant (
        .req0_valid (req0_valid_in),
        .req1_valid (req1_valid_in),
        .can_accept (can_accept),
        .last_grant (lg_to_grant),
        .grant      (grant)
    );

    assign granted         = |grant;
    assign gnt_src         = grant_src(grant);
    assign req0_ready_out  = grant[0];
    assign req1_ready_out  = grant[1];
    assign exec_enable_out = granted;

    // Steer the winner's fields to the execution unit; all zero when idle.
    always_comb begin
        sel = '0;
        if (grant[0])
            sel = req0;
        else if (grant[1])
            sel = req1;
    end

    assign exec_a_out   = sel.a;
    assign exec_b_out   = sel.b;
    assign exec_uop_out = sel.uop;

    // Result slot occupancy register.
    always_ff @(posedge clock_in) begin
        if (reset_in)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    // Next occupancy: a grant always fills; a drain without a grant empties.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (granted) state_d = ST_FULL;
            ST_FULL: begin
                if (granted)
                    state_d = ST_FULL;
                else if (res_ready_in)
                    state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Capture result, tag and source on a grant; otherwise hold (stable while stalled).
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            res_data_out <= '0;
            res_tag_out  <= '0;
            res_src_out  <= 1'b0;
        end else if (granted) begin
            res_data_out <= exec_res_in;
            res_tag_out  <= sel.tag;
            res_src_out  <= gnt_src;
        end
    end

    assign res_valid_out = (state_q == ST_FULL);

endmodule
